// File: rtl/brq_pkg.sv
// Shared types and constants for branch_resolve_queue and its mispredict checker.
package brq_pkg;

  localparam int          BRQ_DEPTH_DEFAULT = 8;
  localparam logic [31:0] PC_STEP           = 32'd4;

  typedef struct packed {
    logic        valid;
    logic        resolved;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        act_taken;
    logic [31:0] act_target;
  } brq_entry_t;

endpackage

// File: rtl/brq_mispredict_check.sv
// Compares a branch's prediction with its actual outcome and computes the
// correct next PC used when the pipeline must be redirected.
module brq_mispredict_check
  import brq_pkg::*;
(
  input  logic        i_pc_valid,
  input  logic [31:0] i_pc,
  input  logic        i_pred_taken,
  input  logic [31:0] i_pred_target,
  input  logic        i_act_taken,
  input  logic [31:0] i_act_target,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc
);

  logic w_dir_wrong;
  logic w_target_wrong;

  always_comb begin
    w_dir_wrong    = (i_pred_taken != i_act_taken);
    // Targets only matter when both the prediction and the outcome are taken.
    w_target_wrong = i_pred_taken && i_act_taken && (i_pred_target != i_act_target);
    o_mispredict   = i_pc_valid && (w_dir_wrong || w_target_wrong);
    o_redirect_pc  = i_act_taken ? i_act_target : (i_pc + PC_STEP);
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order retirement queue for in-flight conditional branches; resolves out of
// order, retires one per cycle, flushes on mispredict. Optional BRQ_STATS_EN adds counters.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH_DEFAULT,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             alloc_valid_in,
  output logic             alloc_ready_out,
  input  logic [31:0]      alloc_pc_in,
  input  logic             alloc_pred_taken_in,
  input  logic [31:0]      alloc_target_in,
  output logic [TAG_W-1:0] alloc_tag_out,
  input  logic             resolve_valid_in,
  input  logic [TAG_W-1:0] resolve_tag_in,
  input  logic             resolve_taken_in,
  input  logic [31:0]      resolve_target_in,
  output logic             update_valid_out,
  output logic [31:0]      update_pc_out,
  output logic             update_taken_out,
  output logic             flush_out,
  output logic [31:0]      redirect_pc_out,
  output logic [TAG_W:0]   count_out
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]      branch_count_out,
  output logic [31:0]      mispredict_count_out
`endif
);

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W + 1)'(DEPTH);

  brq_entry_t       w_entries [DEPTH];
  brq_entry_t       w_head_entry;
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;
  logic             w_alloc;
  logic             w_resolve_hit;
  logic             w_retire;
  logic             w_mispredict;
  logic             w_flush;
  logic [31:0]      w_redirect_pc;

  logic             r_update_valid;
  logic [31:0]      r_update_pc;
  logic             r_update_taken;
  logic             r_flush;
  logic [31:0]      r_redirect_pc;

  assign w_head_entry  = w_entries[r_head];
  assign w_alloc       = alloc_valid_in && alloc_ready_out;
  assign w_resolve_hit = resolve_valid_in && w_entries[resolve_tag_in].valid
                         && !w_entries[resolve_tag_in].resolved;
  assign w_retire      = w_head_entry.valid && w_head_entry.resolved;
  assign w_flush       = w_retire && w_mispredict;

  brq_mispredict_check u_check (
    .i_pc_valid    (w_retire),
    .i_pc          (w_head_entry.pc),
    .i_pred_taken  (w_head_entry.pred_taken),
    .i_pred_target (w_head_entry.pred_target),
    .i_act_taken   (w_head_entry.act_taken),
    .i_act_target  (w_head_entry.act_target),
    .o_mispredict  (w_mispredict),
    .o_redirect_pc (w_redirect_pc)
  );

  // Per-slot storage. Alloc, resolve and retire never target the same slot in
  // one edge: alloc needs a free slot, resolve an unresolved one, retire a resolved one.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      brq_entry_t r_entry;
      logic       w_alloc_here;
      logic       w_resolve_here;
      logic       w_retire_here;

      assign w_alloc_here   = w_alloc && (r_tail == TAG_W'(gi));
      assign w_resolve_here = w_resolve_hit && (resolve_tag_in == TAG_W'(gi));
      assign w_retire_here  = w_retire && (r_head == TAG_W'(gi));

      always_ff @(posedge clk_in) begin
        if (rst_in || w_flush) begin
          r_entry <= '0;
        end else if (w_alloc_here) begin
          r_entry.valid       <= 1'b1;
          r_entry.resolved    <= 1'b0;
          r_entry.pc          <= alloc_pc_in;
          r_entry.pred_taken  <= alloc_pred_taken_in;
          r_entry.pred_target <= alloc_target_in;
          r_entry.act_taken   <= 1'b0;
          r_entry.act_target  <= 32'd0;
        end else if (w_resolve_here) begin
          r_entry.resolved   <= 1'b1;
          r_entry.act_taken  <= resolve_taken_in;
          r_entry.act_target <= resolve_target_in;
        end else if (w_retire_here) begin
          r_entry <= '0;
        end
      end

      assign w_entries[gi] = r_entry;
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_update_valid <= 1'b0;
      r_update_pc    <= 32'd0;
      r_update_taken <= 1'b0;
      r_flush        <= 1'b0;
      r_redirect_pc  <= 32'd0;
    end else begin
      r_update_valid <= w_retire;
      r_flush        <= w_flush;
      if (w_retire) begin
        r_update_pc    <= w_head_entry.pc;
        r_update_taken <= w_head_entry.act_taken;
      end
      if (w_flush) begin
        r_redirect_pc <= w_redirect_pc;
        r_head        <= '0;
        r_tail        <= '0;
        r_count       <= '0;
      end else begin
        if (w_retire) r_head <= r_head + TAG_W'(1);
        if (w_alloc)  r_tail <= r_tail + TAG_W'(1);
        r_count <= r_count + (TAG_W + 1)'(w_alloc) - (TAG_W + 1)'(w_retire);
      end
    end
  end

  assign alloc_ready_out  = (r_count < DEPTH_CNT);
  assign alloc_tag_out    = r_tail;
  assign count_out        = r_count;
  assign update_valid_out = r_update_valid;
  assign update_pc_out    = r_update_pc;
  assign update_taken_out = r_update_taken;
  assign flush_out        = r_flush;
  assign redirect_pc_out  = r_redirect_pc;

`ifdef BRQ_STATS_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_branch_count     <= 32'd0;
      r_mispredict_count <= 32'd0;
    end else begin
      if (w_retire) r_branch_count     <= r_branch_count + 32'd1;
      if (w_flush)  r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign branch_count_out     = r_branch_count;
  assign mispredict_count_out = r_mispredict_count;
`endif

endmodule
